// File: rtl/wb_writer_pkg.sv
// wb_writer_pkg: shared widths, zero constant and the writeback request struct
package wb_writer_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_ADDR_W = $clog2(NREG);
  localparam logic [XLEN-1:0] REG_DATA_ZERO = '0;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_writer_if.sv
// wb_writer_if: pipeline, long-unit, ID-check and register-file write signals; master drives, slave is wb_writer
interface wb_writer_if
  import wb_writer_pkg::*;
#(
  parameter int DW = XLEN,
  parameter int AW = REG_ADDR_W
);
  logic          pipe_valid;
  logic          pipe_reg_write;
  logic [AW-1:0] pipe_rd;
  logic [DW-1:0] pipe_data;
  logic          lu_valid;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic          rs1_rd_en;
  logic          rs2_rd_en;
  logic          rd_chk_en;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [AW-1:0] rd_chk_addr;
  logic          hazard;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  modport master (
    output pipe_valid, pipe_reg_write, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
           issue_en, issue_rd, rs1_rd_en, rs2_rd_en, rd_chk_en, rs1_addr, rs2_addr, rd_chk_addr,
    input  lu_ready, hazard, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  pipe_valid, pipe_reg_write, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
           issue_en, issue_rd, rs1_rd_en, rs2_rd_en, rd_chk_en, rs1_addr, rs2_addr, rd_chk_addr,
    output lu_ready, hazard, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wb_writer_scoreboard.sv
// wb_scoreboard: busy bits for outstanding long-unit results (issue sets, drain clears, set wins) and the ID stall compare
module wb_scoreboard
  import wb_writer_pkg::*;
#(
  parameter int NREG = wb_writer_pkg::NREG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_issue_en,
  input  logic [$clog2(NREG)-1:0]  i_issue_rd,
  input  logic                     i_clr_en,
  input  logic [$clog2(NREG)-1:0]  i_clr_rd,
  input  logic                     i_rs1_rd_en,
  input  logic                     i_rs2_rd_en,
  input  logic                     i_rd_chk_en,
  input  logic [$clog2(NREG)-1:0]  i_rs1_addr,
  input  logic [$clog2(NREG)-1:0]  i_rs2_addr,
  input  logic [$clog2(NREG)-1:0]  i_rd_chk_addr,
  output logic                     o_hazard
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_nxt;
  assign w_set = i_issue_en ? (NREG'(1) << i_issue_rd) : '0;
  assign w_clr = i_clr_en ? (NREG'(1) << i_clr_rd) : '0;
  // set applied after clear so a same-index collision keeps the bit; x0 is masked off
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & {{(NREG-1){1'b1}}, 1'b0};
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else r_busy <= w_busy_nxt;
  end
  assign o_hazard = (i_rs1_rd_en && r_busy[i_rs1_addr]) ||
                    (i_rs2_rd_en && r_busy[i_rs2_addr]) ||
                    (i_rd_chk_en && r_busy[i_rd_chk_addr]);
endmodule

// File: rtl/wb_writer.sv
// wb_writer: arbitrates pipeline and long-unit results onto the registered register-file write port; busy scoreboard when WB_SCOREBOARD_EN is defined
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int XLEN = wb_writer_pkg::XLEN,
  parameter int NREG = wb_writer_pkg::NREG
) (
  input logic       clk,
  input logic       rst,
  wb_writer_if.slave bus
);
  wb_req_t w_pipe;
  wb_req_t w_lu;
  wb_req_t w_sel;
  wb_req_t r_hold;
  wb_req_t r_wr;
  logic    w_accept;
  logic    w_drain;
  assign w_pipe = '{valid: bus.pipe_valid && bus.pipe_reg_write && bus.pipe_rd != '0, rd: bus.pipe_rd, data: bus.pipe_data};
  // an x0 result is accepted but loads an invalid entry, so it is dropped
  assign w_lu = '{valid: bus.lu_rd != '0, rd: bus.lu_rd, data: bus.lu_data};
  assign w_accept = bus.lu_valid && !r_hold.valid;
  assign w_drain = !w_pipe.valid && r_hold.valid;
  assign w_sel = w_pipe.valid ? w_pipe : r_hold;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '{valid: 1'b0, rd: '0, data: REG_DATA_ZERO};
      r_wr <= '{valid: 1'b0, rd: '0, data: REG_DATA_ZERO};
    end else begin
      if (w_accept) r_hold <= w_lu;
      else if (w_drain) r_hold.valid <= 1'b0;
      r_wr <= w_sel.valid ? w_sel : '{valid: 1'b0, rd: r_wr.rd, data: r_wr.data};
    end
  end
  assign bus.lu_ready = !r_hold.valid;
  assign bus.wr_en = r_wr.valid;
  assign bus.wr_addr = r_wr.rd;
  assign bus.wr_data = r_wr.data;
`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(.NREG(NREG)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .i_issue_en    (bus.issue_en),
    .i_issue_rd    (bus.issue_rd),
    .i_clr_en      (w_drain),
    .i_clr_rd      (r_hold.rd),
    .i_rs1_rd_en   (bus.rs1_rd_en),
    .i_rs2_rd_en   (bus.rs2_rd_en),
    .i_rd_chk_en   (bus.rd_chk_en),
    .i_rs1_addr    (bus.rs1_addr),
    .i_rs2_addr    (bus.rs2_addr),
    .i_rd_chk_addr (bus.rd_chk_addr),
    .o_hazard      (bus.hazard)
  );
`else
  logic w_unused;
  assign w_unused = ^{bus.issue_en, bus.issue_rd, bus.rs1_rd_en, bus.rs2_rd_en, bus.rd_chk_en,
                      bus.rs1_addr, bus.rs2_addr, bus.rd_chk_addr};
  assign bus.hazard = 1'b0;
`endif
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed stimulus with an expected-write queue checked by a separate write-port monitor
module tb_wb_writer;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  wb_writer_if bus ();
  wb_writer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    q.push_back('{a: a, d: d});
  endtask
  task automatic pipe(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
    bus.pipe_valid = v;
    bus.pipe_reg_write = w;
    bus.pipe_rd = rd;
    bus.pipe_data = d;
  endtask
  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_rd = rd;
    bus.lu_data = d;
  endtask
  task automatic issue(input logic en, input logic [4:0] rd);
    bus.issue_en = en;
    bus.issue_rd = rd;
  endtask
  always @(negedge clk) begin
    if (bus.wr_en) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got x%0d=0x%08h with no write expected at %0t", bus.wr_addr, bus.wr_data, $time);
      end else begin
        e = q.pop_front();
        if (bus.wr_addr !== e.a || bus.wr_data !== e.d) begin
          errors++;
          $display("FAIL write: got x%0d=0x%08h expected x%0d=0x%08h at %0t", bus.wr_addr, bus.wr_data, e.a, e.d, $time);
        end
      end
    end
  end
  initial begin
    pipe(0, 0, 0, 0);
    lu(0, 0, 0);
    issue(0, 0);
    bus.rs1_rd_en = 0;
    bus.rs2_rd_en = 0;
    bus.rd_chk_en = 0;
    bus.rs1_addr = 0;
    bus.rs2_addr = 0;
    bus.rd_chk_addr = 0;
    step();
    step();
    rst = 0;
    chk("reset_wr_en", 32'(bus.wr_en), 0);
    chk("reset_wr_addr", 32'(bus.wr_addr), 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_lu_ready", 32'(bus.lu_ready), 1);
    chk("reset_hazard", 32'(bus.hazard), 0);
    pipe(1, 1, 5, 32'h1234);
    push(5, 32'h1234);
    step();
    chk("pipe_wr_en", 32'(bus.wr_en), 1);
    pipe(0, 0, 0, 0);
    step();
    chk("idle_wr_en", 32'(bus.wr_en), 0);
    chk("idle_keep_addr", 32'(bus.wr_addr), 5);
    chk("idle_keep_data", bus.wr_data, 32'h1234);
    pipe(1, 1, 1, 32'h11);
    push(1, 32'h11);
    lu(1, 7, 32'hDEAD);
    step();
    lu(0, 0, 0);
    chk("lu_ready_after_accept", 32'(bus.lu_ready), 0);
    pipe(1, 1, 2, 32'h22);
    push(2, 32'h22);
    step();
    chk("lu_ready_starved", 32'(bus.lu_ready), 0);
    pipe(1, 1, 3, 32'h33);
    push(3, 32'h33);
    step();
    chk("lu_ready_starved2", 32'(bus.lu_ready), 0);
    pipe(0, 0, 0, 0);
    push(7, 32'hDEAD);
    step();
    chk("lu_ready_after_drain", 32'(bus.lu_ready), 1);
    chk("drain_wr_addr", 32'(bus.wr_addr), 7);
    step();
    chk("post_drain_wr_en", 32'(bus.wr_en), 0);
    pipe(1, 1, 0, 32'hBAD);
    lu(1, 0, 32'hBEEF);
    step();
    chk("x0_lu_ready", 32'(bus.lu_ready), 1);
    chk("x0_wr_en", 32'(bus.wr_en), 0);
    pipe(1, 0, 4, 32'h44);
    lu(0, 0, 0);
    step();
    chk("nowrite_wr_en", 32'(bus.wr_en), 0);
    pipe(0, 1, 4, 32'h44);
    step();
    chk("novalid_wr_en", 32'(bus.wr_en), 0);
    chk("x0_keep_addr", 32'(bus.wr_addr), 7);
    pipe(0, 0, 0, 0);
    issue(1, 9);
    bus.rs1_rd_en = 1;
    bus.rs1_addr = 9;
    bus.rs2_rd_en = 1;
    bus.rs2_addr = 10;
    step();
    issue(0, 0);
    chk("hz_rs1_busy", 32'(bus.hazard), 32'(SB));
    bus.rs1_rd_en = 0;
    #1;
    chk("hz_rs2_free", 32'(bus.hazard), 0);
    bus.rd_chk_en = 1;
    bus.rd_chk_addr = 9;
    #1;
    chk("hz_rd_chk", 32'(bus.hazard), 32'(SB));
    bus.rd_chk_en = 0;
    bus.rs1_rd_en = 1;
    lu(1, 9, 32'h99);
    push(9, 32'h99);
    step();
    lu(0, 0, 0);
    chk("hz_while_held", 32'(bus.hazard), 32'(SB));
    step();
    chk("hz_after_drain", 32'(bus.hazard), 0);
    chk("ready_after_drain9", 32'(bus.lu_ready), 1);
    issue(1, 9);
    step();
    issue(0, 0);
    lu(1, 9, 32'h55);
    push(9, 32'h55);
    step();
    lu(0, 0, 0);
    issue(1, 9);
    step();
    issue(0, 0);
    chk("hz_set_wins", 32'(bus.hazard), 32'(SB));
    lu(1, 9, 32'h66);
    push(9, 32'h66);
    step();
    lu(0, 0, 0);
    chk("hz_set_wins_held", 32'(bus.hazard), 32'(SB));
    step();
    chk("hz_set_wins_cleared", 32'(bus.hazard), 0);
    issue(1, 0);
    bus.rs1_addr = 0;
    step();
    issue(0, 0);
    chk("hz_x0_never_busy", 32'(bus.hazard), 0);
    issue(1, 3);
    bus.rs1_addr = 3;
    step();
    issue(0, 0);
    lu(1, 3, 32'h333);
    pipe(1, 1, 4, 32'h44);
    push(4, 32'h44);
    step();
    lu(0, 0, 0);
    pipe(0, 0, 0, 0);
    chk("pre_rst_lu_ready", 32'(bus.lu_ready), 0);
    chk("pre_rst_hazard", 32'(bus.hazard), 32'(SB));
    rst = 1;
    step();
    rst = 0;
    chk("rst_lu_ready", 32'(bus.lu_ready), 1);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_hazard", 32'(bus.hazard), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wr_en", 32'(bus.wr_en), 0);
      chk("post_rst_hazard", 32'(bus.hazard), 0);
    end
    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
